bp_fe_realigner: RTL and testbench
==================================

Name: bp_fe_realigner

Overview:
- Sits between the I$ fetch output and the IF2 stage of the PC generator.
- Converts 32-bit aligned fetch blocks into one RISC-V instruction per cycle, handling RVC instructions at either half and 32-bit instructions that straddle two fetch blocks.
- Produces the fetch instruction, PC, valid and partial indications consumed by IF2 scan, RAS and override logic.
- Holds one 16-bit half and its PC across fetches; stalls upstream when two compressed instructions arrive in one block.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p and instr_width_gp (32).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- redirect_v_i  in  1  flush from the FE controller or override; discards all buffered state.
- if2_v_i  in  1  fetch block valid from I$.
- if2_pc_i  in  vaddr_width_p  fetch PC, may be 2-byte aligned.
- if2_data_i  in  32  fetch block data, read at the 4-byte aligned address.
- if2_yumi_o  out  1  fetch block consumed this cycle.
- fetch_ready_i  in  1  downstream (IF2/FE queue) can accept an instruction.
- fetch_instr_o  out  32  realigned instruction; RVC occupies [15:0] and [31:16] is zero.
- fetch_instr_v_o  out  1  fetch_instr_o is a complete instruction.
- fetch_pc_o  out  vaddr_width_p  PC of fetch_instr_o.
- fetch_partial_o  out  1  the instruction started in a previous block (straddle completed) or this block leaves a buffered half.
- fetch_misaligned_o  out  1  misaligned PC with compressed support disabled.

Behaviour:
- Outputs are combinational from the current inputs plus registered state, so IF2 sees the instruction in the fetch cycle.
- Registered state:
  - state_r: E_EMPTY, E_HALF or E_SECOND.
  - half_r[15:0].
  - half_pc_r[vaddr_width_p-1:0].
- Async reset: state_r=E_EMPTY, half_r=0, half_pc_r=0. While reset is asserted all outputs are 0.
- A halfword is compressed iff bits[1:0] != 2'b11.
- Define lo=if2_data_i[15:0], hi=if2_data_i[31:16], mis=if2_pc_i[1].
- E_EMPTY, if2_v_i=1:
  - mis=0, lo 32-bit: emit data, pc=if2_pc_i. Stay E_EMPTY.
  - mis=0, lo compressed: emit lo, pc=if2_pc_i.
    - If hi is compressed: latch hi and pc+2, go E_SECOND.
    - Otherwise: latch hi and pc+2, go E_HALF, fetch_partial_o=1.
  - mis=1, hi compressed: emit hi, pc=if2_pc_i. Stay E_EMPTY.
  - mis=1, hi 32-bit: fetch_instr_v_o=0, fetch_partial_o=1. Latch hi and if2_pc_i, go E_HALF.
- E_HALF, if2_v_i=1:
  - Emit {lo,half_r} with pc=half_pc_r and fetch_partial_o=1.
  - The remaining hi is processed as in E_EMPTY with mis=1, using pc=half_pc_r+4.
- E_SECOND:
  - if2_yumi_o=0 regardless of if2_v_i.
  - Emit {16'b0,half_r} with pc=half_pc_r, then go E_EMPTY.
- if2_yumi_o = if2_v_i & fetch_ready_i & (state_r!=E_SECOND) & ~redirect_v_i.
- State only advances on the cycle it emits, i.e. when fetch_ready_i=1. fetch_ready_i=0 holds all state and outputs stable.
- fetch_instr_v_o=0 whenever no complete instruction exists: if2_v_i=0 outside E_SECOND, or the straddle-start case.
- redirect_v_i:
  - Forces next state E_EMPTY and zeroes half_r.
  - Masks fetch_instr_v_o and if2_yumi_o in the same cycle.
  - Has priority over every other transition, including E_SECOND.
- Address arithmetic is modulo 2^vaddr_width_p (wraps at the top of the VA space).

Optional Feature:
- BP_FE_REALIGNER_COMPRESSED_EN defined: full behaviour above.
- Undefined:
  - state_r is tied to E_EMPTY and half registers are removed.
  - Every valid block emits if2_data_i at if2_pc_i; fetch_partial_o=0.
  - If mis=1: fetch_instr_v_o=0 and fetch_misaligned_o=1.
- fetch_misaligned_o is constant 0 when the feature is defined.

Test Plan:
- Aligned 32-bit: pc=0x1000, data=0x00A00093, ready=1 -> instr_v=1, instr=0x00A00093, pc=0x1000, yumi=1, partial=0.
- Two RVC in one block: pc=0x2000, data=0x45054581 -> cycle0 instr=0x4581 @0x2000, yumi=1. Cycle1 instr=0x4505 @0x2002, yumi=0 despite if2_v_i=1. Cycle2 returns to E_EMPTY.
- Straddle: pc=0x3002, hi=0x0093 -> instr_v=0, partial=1. Next block data=0x????00A0 -> instr=0x00A00093 @0x3002, partial=1.
- Redirect while in E_HALF: hold half, assert redirect_v_i with if2_v_i=1 -> instr_v=0, yumi=0. Next cycle an aligned block emits normally from E_EMPTY.
- Backpressure: E_SECOND with fetch_ready_i=0 for 3 cycles -> state, instr and pc unchanged, yumi=0. Releasing ready emits once.
- Async reset asserted mid-E_SECOND, between clock edges -> all outputs 0 immediately. After release the first block is treated from E_EMPTY.
- Feature undefined, pc=0x4002 -> fetch_misaligned_o=1, instr_v=0.

Source files
------------

// File: rtl/bp_fe_realigner.sv
// bp_fe_realigner
//   Turns 32-bit fetch blocks from the I$ into one RISC-V instruction per
//   cycle. It handles RVC instructions in either half, and 32-bit instructions
//   that straddle two blocks. Outputs are combinational, so IF2 sees the
//   instruction in its fetch cycle.
//
//   Compile-time option: BP_FE_REALIGNER_COMPRESSED_EN
//     defined   : full RVC realignment. One buffered half plus its PC.
//     undefined : no state. Each valid block is passed straight through, and
//                 a misaligned PC raises fetch_misaligned_o.
//
// Ports
//   clk_i, reset_i      clock, async active-high reset
//   redirect_v_i        flush; drops the buffered half and masks valid/yumi
//   if2_v_i/pc_i/data_i fetch block from the I$ (data read 4-byte aligned)
//   if2_yumi_o          fetch block consumed this cycle
//   fetch_ready_i       downstream can take an instruction; 0 freezes state
//   fetch_instr_o/v_o   realigned instruction (RVC zero-extended) and valid
//   fetch_pc_o          PC of fetch_instr_o
//   fetch_partial_o     straddle completed, or a 32-bit half left buffered
//   fetch_misaligned_o  misaligned PC while compressed support is disabled
module bp_fe_realigner #(
    parameter int vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     redirect_v_i,
    input  logic                     if2_v_i,
    input  logic [vaddr_width_p-1:0] if2_pc_i,
    input  logic [31:0]              if2_data_i,
    output logic                     if2_yumi_o,
    input  logic                     fetch_ready_i,
    output logic [31:0]              fetch_instr_o,
    output logic                     fetch_instr_v_o,
    output logic [vaddr_width_p-1:0] fetch_pc_o,
    output logic                     fetch_partial_o,
    output logic                     fetch_misaligned_o
);

    logic                     w_v;
    logic                     w_yumi;
    logic                     w_part;
    logic                     w_misal;
    logic [31:0]              w_instr;
    logic [vaddr_width_p-1:0] w_pc;
    logic                     w_mis;

    assign w_mis = if2_pc_i[1];

`ifdef BP_FE_REALIGNER_COMPRESSED_EN
    typedef enum logic [1:0] {E_EMPTY, E_HALF, E_SECOND} state_e;

    state_e                   r_state, w_state_n;
    logic [15:0]              r_half, w_half_n;
    logic [vaddr_width_p-1:0] r_half_pc, w_half_pc_n;
    logic [15:0]              w_lo, w_hi;
    logic                     w_lo_c, w_hi_c;

    assign w_lo   = if2_data_i[15:0];
    assign w_hi   = if2_data_i[31:16];
    assign w_lo_c = (w_lo[1:0] != 2'b11);
    assign w_hi_c = (w_hi[1:0] != 2'b11);
    assign w_misal = 1'b0;

    always_comb begin
        w_v         = 1'b0;
        w_yumi      = 1'b0;
        w_part      = 1'b0;
        w_instr     = '0;
        w_pc        = '0;
        w_state_n   = r_state;
        w_half_n    = r_half;
        w_half_pc_n = r_half_pc;
        unique case (r_state)
            E_EMPTY: if (if2_v_i) begin
                w_yumi = 1'b1;
                if (!w_mis) begin
                    w_v  = 1'b1;
                    w_pc = if2_pc_i;
                    if (!w_lo_c) begin
                        w_instr = if2_data_i;
                    end else begin
                        // Buffer the upper half. Two RVCs force a stall
                        // cycle (E_SECOND); a 32-bit start waits for the
                        // next block (E_HALF).
                        w_instr     = {16'h0, w_lo};
                        w_half_n    = w_hi;
                        w_half_pc_n = if2_pc_i + vaddr_width_p'(2);
                        w_state_n   = w_hi_c ? E_SECOND : E_HALF;
                        w_part      = ~w_hi_c;
                    end
                end else if (w_hi_c) begin
                    w_v     = 1'b1;
                    w_instr = {16'h0, w_hi};
                    w_pc    = if2_pc_i;
                end else begin
                    w_part      = 1'b1;
                    w_half_n    = w_hi;
                    w_half_pc_n = if2_pc_i;
                    w_state_n   = E_HALF;
                end
            end
            E_HALF: if (if2_v_i) begin
                // Complete the straddle with lo. hi is then the new leftover:
                // a compressed hi still needs its own emit cycle.
                w_yumi      = 1'b1;
                w_v         = 1'b1;
                w_part      = 1'b1;
                w_instr     = {w_lo, r_half};
                w_pc        = r_half_pc;
                w_half_n    = w_hi;
                w_half_pc_n = r_half_pc + vaddr_width_p'(4);
                w_state_n   = w_hi_c ? E_SECOND : E_HALF;
            end
            E_SECOND: begin
                w_v       = 1'b1;
                w_instr   = {16'h0, r_half};
                w_pc      = r_half_pc;
                w_state_n = E_EMPTY;
            end
            default: w_state_n = E_EMPTY;
        endcase
        if (redirect_v_i) begin
            w_state_n = E_EMPTY;
            w_half_n  = '0;
        end
    end

    // A redirect flushes even while downstream is stalled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= E_EMPTY;
            r_half    <= '0;
            r_half_pc <= '0;
        end else if (redirect_v_i || fetch_ready_i) begin
            r_state   <= w_state_n;
            r_half    <= w_half_n;
            r_half_pc <= w_half_pc_n;
        end
    end
`else
    logic w_unused_clk;
    assign w_unused_clk = clk_i;

    always_comb begin
        w_v     = if2_v_i & ~w_mis;
        w_yumi  = if2_v_i;
        w_part  = 1'b0;
        w_misal = if2_v_i & w_mis;
        w_instr = if2_v_i ? if2_data_i : '0;
        w_pc    = if2_v_i ? if2_pc_i : '0;
    end
`endif

    // Outputs read 0 while reset is held, without waiting for a clock edge.
    assign fetch_instr_v_o    = w_v & ~reset_i & ~redirect_v_i;
    assign if2_yumi_o         = w_yumi & fetch_ready_i & ~reset_i & ~redirect_v_i;
    assign fetch_partial_o    = w_part & ~reset_i & ~redirect_v_i;
    assign fetch_misaligned_o = w_misal & ~reset_i;
    assign fetch_instr_o      = reset_i ? '0 : w_instr;
    assign fetch_pc_o         = reset_i ? '0 : w_pc;

endmodule

// File: tb/tb_bp_fe_realigner.sv
module tb_bp_fe_realigner;
    localparam int VA = 39;

    logic          clk = 1'b0;
    logic          rst;
    logic          redir, if2_v, yumi, rdy, instr_v, part, misal;
    logic [VA-1:0] if2_pc, pc_o;
    logic [31:0]   data, instr;

    bp_fe_realigner #(.vaddr_width_p(VA)) dut (
        .clk_i(clk), .reset_i(rst), .redirect_v_i(redir),
        .if2_v_i(if2_v), .if2_pc_i(if2_pc), .if2_data_i(data),
        .if2_yumi_o(yumi), .fetch_ready_i(rdy),
        .fetch_instr_o(instr), .fetch_instr_v_o(instr_v), .fetch_pc_o(pc_o),
        .fetch_partial_o(part), .fetch_misaligned_o(misal)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Reference model: a stream of pending halfwords (each with its PC).
    // Each cycle it emits at most one instruction from the head.
    typedef struct {
        logic [15:0]   h;
        logic [VA-1:0] pc;
    } hw_t;

    hw_t           q[$];
    hw_t           nq[$];
    logic          e_v, e_yumi, e_part, e_mis;
    logic [31:0]   e_instr;
    logic [VA-1:0] e_pc;

    function automatic logic isc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    task automatic model();
        hw_t L[$];
        hw_t t;
        e_v = 0; e_yumi = 0; e_part = 0; e_mis = 0; e_instr = '0; e_pc = '0;
        nq = q;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
        if (q.size() == 1 && isc(q[0].h)) begin
            e_v = 1; e_instr = {16'h0, q[0].h}; e_pc = q[0].pc;
            nq.delete();
        end else if (if2_v) begin
            e_yumi = rdy;
            L = q;
            if (q.size() == 1) begin
                t.h = data[15:0];  t.pc = q[0].pc + VA'(2); L.push_back(t);
                t.h = data[31:16]; t.pc = q[0].pc + VA'(4); L.push_back(t);
            end else begin
                if (!if2_pc[1]) begin t.h = data[15:0]; t.pc = if2_pc; L.push_back(t); end
                t.h = data[31:16];
                t.pc = if2_pc[1] ? if2_pc : if2_pc + VA'(2);
                L.push_back(t);
            end
            if (isc(L[0].h)) begin
                e_v = 1; e_instr = {16'h0, L[0].h}; e_pc = L[0].pc;
                void'(L.pop_front());
            end else if (L.size() >= 2) begin
                e_v = 1; e_instr = {L[1].h, L[0].h}; e_pc = L[0].pc;
                e_part = (q.size() == 1);
                void'(L.pop_front()); void'(L.pop_front());
            end
            if (L.size() != 0 && !isc(L[0].h)) e_part = 1;
            nq = L;
        end
`else
        e_v = if2_v & ~if2_pc[1];
        e_mis = if2_v & if2_pc[1];
        e_yumi = if2_v & rdy;
        e_instr = data; e_pc = if2_pc;
`endif
        if (redir) begin e_v = 0; e_yumi = 0; e_part = 0; end
    endtask

    task automatic drive(input string tag, input logic v, input logic [VA-1:0] p,
                         input logic [31:0] d, input logic r, input logic rd);
        @(negedge clk);
        if2_v = v; if2_pc = p; data = d; rdy = r; redir = rd;
        #1;
        model();
        chk({tag, ".v"}, 64'(instr_v), 64'(e_v));
        chk({tag, ".yumi"}, 64'(yumi), 64'(e_yumi));
        chk({tag, ".part"}, 64'(part), 64'(e_part));
        chk({tag, ".mis"}, 64'(misal), 64'(e_mis));
        if (e_v) begin
            chk({tag, ".instr"}, 64'(instr), 64'(e_instr));
            chk({tag, ".pc"}, 64'(pc_o), 64'(e_pc));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (redir) q.delete();
        else if (rdy) q = nq;
    endtask

    function automatic logic [15:0] mkh();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else h[1:0] = 2'($urandom_range(0, 2));
        return h;
    endfunction

    task automatic rst_check(input string tag);
        chk({tag, ".v"}, 64'(instr_v), 64'h0);
        chk({tag, ".yumi"}, 64'(yumi), 64'h0);
        chk({tag, ".part"}, 64'(part), 64'h0);
        chk({tag, ".mis"}, 64'(misal), 64'h0);
        chk({tag, ".instr"}, 64'(instr), 64'h0);
        chk({tag, ".pc"}, 64'(pc_o), 64'h0);
    endtask

    initial begin
        logic [VA-1:0] p;
        rst = 1; redir = 0; if2_v = 1; if2_pc = VA'('h1002); data = 32'h00A00093; rdy = 1;
        #2 rst_check("reset");
        @(negedge clk); rst = 0;

`ifdef BP_FE_REALIGNER_COMPRESSED_EN
        drive("al32", 1, VA'('h1000), 32'h00A00093, 1, 0);
        chk("al32.instr_k", 64'(instr), 64'h00A00093);
        chk("al32.yumi_k", 64'(yumi), 64'h1);
        adv();
        drive("rvc2a", 1, VA'('h2000), 32'h45054581, 1, 0);
        chk("rvc2a.instr_k", 64'(instr), 64'h4581);
        adv();
        drive("rvc2b", 1, VA'('h2000), 32'h45054581, 1, 0);
        chk("rvc2b.instr_k", 64'(instr), 64'h4505);
        chk("rvc2b.pc_k", 64'(pc_o), 64'h2002);
        chk("rvc2b.yumi_k", 64'(yumi), 64'h0);
        adv();
        drive("rvc2c", 1, VA'('h1000), 32'h00A00093, 1, 0);
        chk("rvc2c.instr_k", 64'(instr), 64'h00A00093);
        adv();
        drive("strA", 1, VA'('h3002), 32'h00931234, 1, 0);
        chk("strA.v_k", 64'(instr_v), 64'h0);
        chk("strA.part_k", 64'(part), 64'h1);
        adv();
        drive("strB", 1, VA'('h3004), 32'h567300A0, 1, 0);
        chk("strB.instr_k", 64'(instr), 64'h00A00093);
        chk("strB.pc_k", 64'(pc_o), 64'h3002);
        chk("strB.part_k", 64'(part), 64'h1);
        adv();
        drive("redir", 1, VA'('h3008), 32'h00A00093, 1, 1);
        chk("redir.v_k", 64'(instr_v), 64'h0);
        chk("redir.yumi_k", 64'(yumi), 64'h0);
        adv();
        drive("postredir", 1, VA'('h1000), 32'h00A00093, 1, 0);
        chk("postredir.pc_k", 64'(pc_o), 64'h1000);
        adv();
        drive("bp0", 1, VA'('h2000), 32'h45054581, 1, 0);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive("bp", 1, VA'('h2000), 32'h45054581, 0, 0);
            chk("bp.instr_k", 64'(instr), 64'h4505);
            chk("bp.pc_k", 64'(pc_o), 64'h2002);
            chk("bp.yumi_k", 64'(yumi), 64'h0);
            adv();
        end
        drive("bprel", 1, VA'('h2000), 32'h45054581, 1, 0);
        adv();
        drive("bpdone", 0, VA'('h2000), 32'h45054581, 1, 0);
        adv();
        drive("rs0", 1, VA'('h2000), 32'h45054581, 1, 0);
        adv();
        @(negedge clk); if2_v = 1; rdy = 1; redir = 0;
        #1 rst = 1;
        #1 rst_check("rstmid");
        q.delete();
        @(negedge clk); rst = 0;
        drive("rs1", 1, VA'('h1000), 32'h00A00093, 1, 0);
        chk("rs1.instr_k", 64'(instr), 64'h00A00093);
        adv();
`else
        drive("al32", 1, VA'('h1000), 32'h00A00093, 1, 0);
        chk("al32.instr_k", 64'(instr), 64'h00A00093);
        chk("al32.pc_k", 64'(pc_o), 64'h1000);
        chk("al32.yumi_k", 64'(yumi), 64'h1);
        chk("al32.part_k", 64'(part), 64'h0);
        adv();
        drive("misal", 1, VA'('h4002), 32'h00A00093, 1, 0);
        chk("misal.mis_k", 64'(misal), 64'h1);
        chk("misal.v_k", 64'(instr_v), 64'h0);
        adv();
        drive("redir", 1, VA'('h1000), 32'h00A00093, 1, 1);
        chk("redir.v_k", 64'(instr_v), 64'h0);
        adv();
        drive("stall", 1, VA'('h1004), 32'h12345678, 0, 0);
        chk("stall.yumi_k", 64'(yumi), 64'h0);
        adv();
        @(negedge clk); if2_v = 1; if2_pc = VA'('h4002); rdy = 1; redir = 0;
        #1 rst = 1;
        #1 rst_check("rstmid");
        @(negedge clk); rst = 0;
`endif

        for (int i = 0; i < 800; i++) begin
            p = VA'({$urandom, $urandom});
            p[0] = 1'b0;
            p[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin p = '1; p[0] = 1'b0; end
            drive("rnd", 1'($urandom_range(0, 3) != 0), p, {mkh(), mkh()},
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 15) == 0));
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
